// File: rtl/pwm_pkg.sv
// Shared PWM definitions: capture FSM state and duty-cycle scaling constants.
package pwm_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StMeasure
  } cap_state_e;

  localparam int unsigned DUTY_W     = 7;
  localparam int unsigned DUTY_SCALE = 100;

endpackage

// File: rtl/pwm_duty_div.sv
// Restoring divider producing DUTY_W quotient bits, one per cycle.
// The quotient is known to fit in DUTY_W bits (num < 2**DUTY_W * den), so the
// divisor starts shifted left by DUTY_W-1 and walks down one bit per cycle.
// A start while busy restarts with the new operands; abort drops the job.
module pwm_duty_div
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [CNT_W+DUTY_W-1:0] num,
  input  logic [CNT_W-1:0]        den,
  output logic                    busy,
  output logic [DUTY_W-1:0]       q,
  output logic                    done
);

  localparam int unsigned NW = CNT_W + DUTY_W;

  logic [NW-1:0]     rem_q, rem_d;
  logic [NW-1:0]     dsh_q, dsh_d;
  logic [DUTY_W-1:0] quo_q, quo_d;
  logic [DUTY_W-1:0] res_q, res_d;
  logic [2:0]        step_q, step_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ge;

  assign ge = (rem_q >= dsh_q);

  // Next-state: load on start, otherwise one restoring step per busy cycle.
  always_comb begin
    rem_d  = rem_q;
    dsh_d  = dsh_q;
    quo_d  = quo_q;
    res_d  = res_q;
    step_d = step_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (abort) begin
      busy_d = 1'b0;
    end else if (start) begin
      rem_d  = num;
      dsh_d  = {1'b0, den, {(DUTY_W-1){1'b0}}};
      quo_d  = '0;
      step_d = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (ge) rem_d = rem_q - dsh_q;
      quo_d  = {quo_q[DUTY_W-2:0], ge};
      dsh_d  = dsh_q >> 1;
      step_d = step_q + 3'd1;
      if (step_q == 3'(DUTY_W - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        res_d  = {quo_q[DUTY_W-2:0], ge};
      end
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q  <= '0;
      dsh_q  <= '0;
      quo_q  <= '0;
      res_q  <= '0;
      step_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      dsh_q  <= dsh_d;
      quo_q  <= quo_d;
      res_q  <= res_d;
      step_q <= step_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy = busy_q;
  assign q    = res_q;
  assign done = done_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM input capture: measures period and high time of pwm_in in clk cycles,
// flags an edgeless input with timeout. Optional duty-cycle percentage output
// enabled by defining PWM_CAPTURE_DUTY_EN; otherwise duty_pct/duty_valid are 0.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT     = 65535,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  high_time,
  output logic              valid,
  output logic              timeout,
  output logic              level,
  output logic [DUTY_W-1:0] duty_pct,
  output logic              duty_valid
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s, s_dly_q, rise, fall;
  cap_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0]       hi_lat_q, hi_lat_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic [CNT_W-1:0]       high_q, high_d;
  logic                   valid_q, valid_d;
  logic                   timeout_q, timeout_d;

  assign sync_d  = {sync_q[SYNC_STAGES-2:0], pwm_in};
  assign s       = sync_q[SYNC_STAGES-1];
  assign rise    = s & ~s_dly_q;
  assign fall    = ~s & s_dly_q;
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  // Capture FSM: first rise arms, later rises report, long silence times out.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_lat_d  = hi_lat_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    if (!enable) begin
      state_d  = StIdle;
      cnt_d    = '0;
      hi_lat_d = '0;
    end else begin
      if (rise) timeout_d = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rise) begin
            state_d = StMeasure;
            cnt_d   = '0;
          end
        end
        StMeasure: begin
          if (fall) hi_lat_d = cnt_inc;
          if (rise) begin
            period_d = cnt_inc;
            high_d   = hi_lat_q;
            valid_d  = 1'b1;
            cnt_d    = '0;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_d   = StIdle;
            timeout_d = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Synchronizer, edge-detect delay and capture registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= '0;
      s_dly_q   <= 1'b0;
      state_q   <= StIdle;
      cnt_q     <= '0;
      hi_lat_q  <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      s_dly_q   <= s;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_lat_q  <= hi_lat_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign valid     = valid_q & enable;
  assign timeout   = timeout_q;
  assign level     = s;

`ifdef PWM_CAPTURE_DUTY_EN
  logic                    div_start, div_busy, div_done;
  logic [DUTY_W-1:0]       div_q;
  logic [CNT_W+DUTY_W-1:0] div_num;

  // Operands are taken in the same cycle the new period/high_time are latched.
  assign div_start = enable && (state_q == StMeasure) && rise;
  assign div_num   = (CNT_W+DUTY_W)'(hi_lat_q) * (CNT_W+DUTY_W)'(DUTY_SCALE);

  pwm_duty_div #(
    .CNT_W(CNT_W)
  ) u_duty_div (
    .clk  (clk),
    .reset(reset),
    .start(div_start),
    .abort(~enable & div_busy),
    .num  (div_num),
    .den  (cnt_inc),
    .busy (div_busy),
    .q    (div_q),
    .done (div_done)
  );

  assign duty_pct   = div_q;
  assign duty_valid = div_done & enable;
`else
  assign duty_pct   = '0;
  assign duty_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: stimulus pushes expected measurements,
// a negedge monitor pops and compares on every valid / duty_valid pulse.
module tb_pwm_capture;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 100;
  localparam int SYNC    = 2;

`ifdef PWM_CAPTURE_DUTY_EN
  localparam int HOLD_PCT = 37;
`else
  localparam int HOLD_PCT = 0;
`endif

  logic             clk = 1'b0;
  logic             reset, enable, pwm_in;
  logic [CNT_W-1:0] period, high_time;
  logic             valid, timeout, level, duty_valid;
  logic [6:0]       duty_pct;

  typedef struct {
    int per;
    int hi;
  } meas_t;

  meas_t meas_q[$];
  int    duty_q[$];
  int    n_vec  = 0;
  int    n_miss = 0;

  pwm_capture #(
    .CNT_W      (CNT_W),
    .TIMEOUT    (TIMEOUT),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .pwm_in    (pwm_in),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .timeout   (timeout),
    .level     (level),
    .duty_pct  (duty_pct),
    .duty_valid(duty_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every output pulse must match the oldest pending expectation.
  meas_t m;
  int    d;
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (valid !== 1'b0) begin
        if (meas_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_valid: got valid=%b period=%0d high=%0d, expected none (t=%0t)",
                   valid, period, high_time, $time);
        end else begin
          m = meas_q.pop_front();
          chk("period", int'(period), m.per);
          chk("high_time", int'(high_time), m.hi);
        end
      end
      if (duty_valid !== 1'b0) begin
        if (duty_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_duty_valid: got duty_valid=%b duty_pct=%0d, expected none (t=%0t)",
                   duty_valid, duty_pct, $time);
        end else begin
          d = duty_q.pop_front();
          chk("duty_pct", int'(duty_pct), d);
        end
      end
    end
  end

  task automatic hold(input logic v, input int n);
    pwm_in = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int h, input int l);
    hold(1'b1, h);
    hold(1'b0, l);
  endtask

  task automatic exp_m(input int p, input int h, input int n);
    meas_t e;
    e.per = p;
    e.hi  = h;
    repeat (n) meas_q.push_back(e);
  endtask

  task automatic exp_d(input int pct, input int n);
`ifdef PWM_CAPTURE_DUTY_EN
    repeat (n) duty_q.push_back(pct);
`endif
  endtask

  task automatic chk_drained(input string tag);
    chk({tag, "_meas_pending"}, meas_q.size(), 0);
    chk({tag, "_duty_pending"}, duty_q.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_period"}, int'(period), 0);
    chk({tag, "_high_time"}, int'(high_time), 0);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_timeout"}, int'(timeout), 0);
    chk({tag, "_level"}, int'(level), 0);
    chk({tag, "_duty_pct"}, int'(duty_pct), 0);
    chk({tag, "_duty_valid"}, int'(duty_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;
    reset  = 1'b0;
    enable = 1'b1;
    hold(1'b0, 5);

    // 3/5 waveform, then switch to 15/5.
    exp_m(8, 3, 5);
    exp_d(37, 5);
    exp_m(20, 15, 2);
    exp_d(75, 2);
    repeat (5) pulse(3, 5);
    repeat (3) pulse(15, 5);
    hold(1'b0, 110);
    chk("stuck_low_timeout", int'(timeout), 1);
    chk("stuck_low_level", int'(level), 0);
    chk_drained("a");

    // Stuck high, then recovery into 10/9 with a 7-cycle period aborting a division.
    hold(1'b1, TIMEOUT + 10);
    chk("stuck_high_timeout", int'(timeout), 1);
    chk("stuck_high_level", int'(level), 1);
    hold(1'b0, 4);
    exp_m(10, 9, 3);
    exp_m(7, 4, 1);
    exp_d(90, 2);
    exp_d(57, 1);
    pulse(9, 1);
    chk("timeout_cleared", int'(timeout), 0);
    repeat (2) pulse(9, 1);
    pulse(4, 3);
    pulse(9, 1);
    hold(1'b0, 110);
    chk("abort_timeout", int'(timeout), 1);
    chk_drained("b");

    // Reset in the middle of a measurement.
    exp_m(8, 3, 1);
    exp_d(37, 1);
    pulse(3, 5);
    hold(1'b1, 3);
    hold(1'b0, 15);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midreset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_drained("c0");
    hold(1'b0, 3);
    exp_m(8, 3, 2);
    exp_d(37, 2);
    repeat (3) pulse(3, 5);
    hold(1'b0, 15);
    chk_drained("c1");

    // Enable drop during MEASURE: results hold, re-enable re-arms.
    enable = 1'b0;
    hold(1'b0, 5);
    chk("dis_valid", int'(valid), 0);
    chk("dis_period", int'(period), 8);
    chk("dis_high_time", int'(high_time), 3);
    chk("dis_timeout", int'(timeout), 0);
    chk("dis_duty_pct", int'(duty_pct), HOLD_PCT);
    enable = 1'b1;
    hold(1'b0, 3);
    exp_m(10, 5, 2);
    exp_d(50, 2);
    repeat (3) pulse(5, 5);
    hold(1'b0, 20);
    chk("final_period", int'(period), 10);
    chk_drained("d");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
